mul_div_unit: RTL and testbench

Multi-cycle signed 32×32 multiply and 32/32 divide unit in the ALU path of the datapath. Operands come from the Y register (A) and the bus (B). The 64-bit result is produced as {result_hi, result_lo} for loading into Z, and from Z into HI/LO. Multiply uses radix-4 Booth recoding. Divide uses signed restoring division. Both are sequenced by an internal FSM with a start/busy/done handshake, so the control unit stalls its T-state until done.

---
 rtl/mul_div_unit.sv | 194 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed 32x32 multiply (radix-4 Booth) and 32/32 divide (restoring, truncating).
// Optional feature macro: MULDIV_DIVIDE_EN compiles in the DIV/FIX paths and div_by_zero.
module mul_div_unit (
  input  logic        Clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_hi,
  output logic [31:0] result_lo,
  output logic        div_by_zero
);

  localparam logic [4:0] OpMul = 5'b01111;

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [33:0] acc_q, acc_d;
  logic [33:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic        guard_q, guard_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [33:0] pp;
  logic [33:0] acc_sum;

`ifdef MULDIV_DIVIDE_EN
  localparam logic [4:0] OpDiv = 5'b10000;

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_q, dbz_d;
  logic [31:0] a_mag, b_mag;
  logic [32:0] div_sh, div_diff;
  logic        div_ge;

  assign a_mag    = a[31] ? (32'd0 - a) : a;
  assign b_mag    = b[31] ? (32'd0 - b) : b;
  assign div_sh   = {rem_q, quo_q[31]};
  assign div_diff = div_sh - {1'b0, dvs_q};
  // div_sh < 2*dvs always, so bit 32 of the difference is a clean borrow
  assign div_ge   = ~div_diff[32];
`endif

  // Booth digit from {b[2i+1], b[2i], b[2i-1]}; 34-bit acc absorbs +/-2A
  always_comb begin
    pp = 34'd0;
    case ({mplr_q[1:0], guard_q})
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = {mcand_q[32:0], 1'b0};
      3'b100:         pp = 34'd0 - {mcand_q[32:0], 1'b0};
      3'b101, 3'b110: pp = 34'd0 - mcand_q;
      default:        pp = 34'd0;
    endcase
  end

  assign acc_sum = acc_q + pp;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    guard_d  = guard_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
`ifdef MULDIV_DIVIDE_EN
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start && opcode == OpMul) begin
          state_d = StMul;
          cnt_d   = 5'd0;
          acc_d   = 34'd0;
          mcand_d = {{2{a[31]}}, a};
          mplr_d  = b;
          guard_d = 1'b0;
`ifdef MULDIV_DIVIDE_EN
          dbz_d   = 1'b0;
        end else if (start && opcode == OpDiv) begin
          if (b == 32'd0) begin
            state_d  = StDone;
            res_hi_d = a;
            res_lo_d = 32'hFFFF_FFFF;
            dbz_d    = 1'b1;
          end else begin
            state_d   = StDiv;
            cnt_d     = 5'd0;
            rem_d     = 32'd0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a[31] ^ b[31];
            neg_rem_d = a[31];
            dbz_d     = 1'b0;
          end
`endif
        end
      end
      StMul: begin
        acc_d   = {{2{acc_sum[33]}}, acc_sum[33:2]};
        mplr_d  = {acc_sum[1:0], mplr_q[31:2]};
        guard_d = mplr_q[1];
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d  = StDone;
          res_hi_d = acc_sum[33:2];
          res_lo_d = {acc_sum[1:0], mplr_q[31:2]};
        end
      end
`ifdef MULDIV_DIVIDE_EN
      StDiv: begin
        rem_d = div_ge ? div_diff[31:0] : div_sh[31:0];
        quo_d = {quo_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        state_d  = StDone;
        res_lo_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        res_hi_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      acc_q    <= 34'd0;
      mcand_q  <= 34'd0;
      mplr_q   <= 32'd0;
      guard_q  <= 1'b0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      guard_q  <= guard_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

`ifdef MULDIV_DIVIDE_EN
  always_ff @(posedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
  assign done      = (state_q == StDone);
  assign result_hi = res_hi_q;
  assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; DIV checks follow MULDIV_DIVIDE_EN.
module tb_mul_div_unit;

  localparam logic [4:0] OpMul = 5'b01111;
  localparam logic [4:0] OpDiv = 5'b10000;

  logic        Clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit dut (
    .Clock       (Clock),
    .clear_n     (clear_n),
    .start       (start),
    .opcode      (opcode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_hi   (result_hi),
    .result_lo   (result_lo),
    .div_by_zero (div_by_zero)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a request so the next rising edge is the accepting edge k; return at k + 1ns
  task automatic issue(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv);
    opcode = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    @(posedge Clock);
    #1;
    start  = 1'b0;
    opcode = 5'd0;
    a      = 32'hDEAD_BEEF;
    b      = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 50) begin
      @(posedge Clock);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int lat, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int n;
    issue(op, av, bv);
    check({tag, "_busy"}, 64'(busy), 64'(lat != 0));
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_hi"}, 64'(result_hi), 64'(ehi));
    check({tag, "_lo"}, 64'(result_lo), 64'(elo));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge Clock);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int saw_done;
    clear_n = 1'b0;
    start   = 1'b0;
    opcode  = 5'd0;
    a       = 32'd0;
    b       = 32'd0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    clear_n = 1'b1;
    @(posedge Clock);
    #1;

    run_op("mul_small", OpMul, 32'h0000_0012, 32'h0000_0014, 16, 32'h0, 32'h0000_0168);
    run_op("mul_neg", OpMul, 32'hFFFF_FFF9, 32'h0000_0003, 16, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mul_min", OpMul, 32'h8000_0000, 32'h8000_0000, 16, 32'h4000_0000, 32'h0);

    repeat (3) @(posedge Clock);
    #1;
    check("hold_hi", 64'(result_hi), 64'h4000_0000);
    check("hold_lo", 64'(result_lo), 64'd0);

    // Illegal opcode is ignored
    issue(5'b00001, 32'd5, 32'd5);
    check("ill_busy", 64'(busy), 64'd0);
    check("ill_done", 64'(done), 64'd0);
    @(posedge Clock);
    #1;
    check("ill_done2", 64'(done), 64'd0);

    // Back-to-back: start held through DONE
    issue(OpMul, 32'd3, 32'd4);
    wait_done(n);
    check("b2b1_lat", 64'(n), 64'd16);
    check("b2b1_lo", 64'(result_lo), 64'd12);
    opcode = OpMul;
    a      = 32'd5;
    b      = 32'hFFFF_FFFE;
    start  = 1'b1;
    @(posedge Clock);
    #1;
    start  = 1'b0;
    a      = 32'h1234_5678;
    b      = 32'h9ABC_DEF0;
    check("b2b_no_repeat", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_hold_lo", 64'(result_lo), 64'd12);
    wait_done(n);
    check("b2b2_lat", 64'(n), 64'd16);
    check("b2b2_hi", 64'(result_hi), 64'hFFFF_FFFF);
    check("b2b2_lo", 64'(result_lo), 64'hFFFF_FFF6);
    @(posedge Clock);
    #1;
    check("b2b2_pulse", 64'(done), 64'd0);

    // Start while busy is ignored; the original MUL completes on time
    issue(OpMul, 32'h0000_0012, 32'h0000_0014);
    repeat (4) @(posedge Clock);
    #1;
    opcode = OpMul;
    a      = 32'd3;
    b      = 32'd3;
    start  = 1'b1;
    @(posedge Clock);
    #1;
    start  = 1'b0;
    wait_done(n);
    check("ign_lat", 64'(n + 5), 64'd16);
    check("ign_lo", 64'(result_lo), 64'h168);
    @(posedge Clock);
    #1;

`ifdef MULDIV_DIVIDE_EN
    run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("div_neg_dbz", 64'(div_by_zero), 64'd0);
    run_op("div_negb", OpDiv, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("div_min", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    check("div_min_dbz", 64'(div_by_zero), 64'd0);
    run_op("div_zero", OpDiv, 32'd100, 32'd0, 0, 32'h0000_0064, 32'hFFFF_FFFF);
    check("dbz_sticky", 64'(div_by_zero), 64'd1);
    issue(OpMul, 32'd2, 32'd3);
    check("dbz_clear", 64'(div_by_zero), 64'd0);
    wait_done(n);
    check("dbz_mul_lo", 64'(result_lo), 64'd6);
    @(posedge Clock);
    #1;
`else
    issue(OpDiv, 32'd100, 32'd0);
    check("nodiv_busy", 64'(busy), 64'd0);
    check("nodiv_done", 64'(done), 64'd0);
    check("nodiv_dbz", 64'(div_by_zero), 64'd0);
    saw_done = 0;
    repeat (35) begin
      @(posedge Clock);
      #1;
      if (done) saw_done = 1;
    end
    check("nodiv_never_done", 64'(saw_done), 64'd0);
    check("nodiv_lo_hold", 64'(result_lo), 64'h168);
`endif

    // Asynchronous reset mid-operation
    issue(OpMul, 32'h0000_0012, 32'h0000_0014);
    repeat (4) @(posedge Clock);
    #1;
    opcode = OpMul;
    a      = 32'd3;
    b      = 32'd3;
    start  = 1'b1;
    @(posedge Clock);
    #1;
    start  = 1'b0;
    check("mid_busy", 64'(busy), 64'd1);
    repeat (2) @(posedge Clock);
    #3;
    clear_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(result_hi), 64'd0);
    check("arst_lo", 64'(result_lo), 64'd0);
    check("arst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge Clock);
    #1;
    clear_n = 1'b1;
    saw_done = 0;
    repeat (25) begin
      @(posedge Clock);
      #1;
      if (done) saw_done = 1;
    end
    check("arst_no_done", 64'(saw_done), 64'd0);
    run_op("post_rst", OpMul, 32'h0000_0012, 32'h0000_0014, 16, 32'h0, 32'h0000_0168);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
